sdram_ch_reader: RTL and testbench
==================================

Name: sdram_ch_reader

Overview:
- Read-side companion to the per-channel write stimulus used on the SDRAM user port.
- Issues one read request on a `chN_r_*` channel of `sdram_user_top` and waits for the transfer to complete.
- Pops the channel read FIFO and checks every word against an incrementing pattern (`expect_start`, `expect_start+1`, …).
- Reports pass/fail, error count and first mismatch. Used in simulation and as an on-board self-test.

Parameters:
- ADDR_W, 21, SDRAM user address width.
- NUM_W, 9, burst word-count width.
- DATA_W, 32, user data width.
- TIMEOUT, 4096, maximum cycles between request and r_done; used only when `SDRAM_READER_TIMEOUT_EN` is defined.

Ports:
- clk  in  1  channel read clock; every port is synchronous to it.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that starts a check; ignored unless idle.
- base_addr  in  ADDR_W  SDRAM start address; sampled on start.
- number  in  NUM_W  word count; sampled on start.
- expect_start  in  DATA_W  expected first word; sampled on start.
- r_addr  out  ADDR_W  to `chN_r_addr`; holds the latched base_addr.
- r_number  out  NUM_W  to `chN_r_number`; holds the latched number.
- r_dr_en  out  1  to `chN_r_dr_en`; one-cycle request pulse.
- r_ack  in  1  from `chN_r_ack`; transfer has started.
- r_done  in  1  from `chN_r_done`; all words are in the read FIFO.
- r_fo_en  out  1  to `chN_r_fo_en`; FIFO pop.
- r_data  in  DATA_W  from `chN_r_data`; valid one cycle after r_fo_en.
- busy  out  1  high from start until the result is posted.
- chk_done  out  1  one-cycle pulse when the result is posted.
- pass  out  1  result: high when the check is clean; held until the next start.
- err_cnt  out  NUM_W  number of mismatching words (saturating).
- rd_cnt  out  NUM_W  number of words compared.
- first_err_idx  out  NUM_W  index of the first mismatch; all-ones when there is none.
- first_err_data  out  DATA_W  data word at the first mismatch.
- timeout  out  1  high when r_done never arrived (timeout build only).

Behaviour:
- Reset values:
  - All outputs are 0, except first_err_idx, which is all-ones.
  - r_addr and r_number are 0. State is IDLE.
- IDLE:
  - On start, latch base_addr, number and expect_start.
  - Clear err_cnt, rd_cnt, pass and timeout; set first_err_idx to all-ones.
  - Set busy. Go to REQ, or to REPORT if number == 0.
- REQ:
  - Assert r_dr_en for exactly one cycle, then go to WAIT_DONE.
  - r_addr and r_number stay stable from REQ until REPORT.
- WAIT_DONE:
  - r_ack is informational; an optional SVA checks that it arrives before r_done.
  - On r_done, go to POP.
  - A start pulse in this or any non-IDLE state is ignored.
- POP:
  - Assert r_fo_en for exactly `number` consecutive cycles, counted by pop_cnt.
  - The compare pipeline is one stage: at cycle k+1 compare r_data with exp, where exp starts at expect_start and increments by 1 per compare, wrapping modulo 2^DATA_W.
  - On a mismatch, err_cnt increments, saturating at all-ones.
  - The first mismatch captures first_err_idx = compare index and first_err_data = r_data.
  - After the last pop, go to DRAIN.
- DRAIN:
  - One cycle that compares the final word, then go to REPORT.
  - At this point rd_cnt == number.
- REPORT:
  - pass = (err_cnt == 0) && !timeout.
  - Pulse chk_done for one cycle, deassert busy and return to IDLE.
  - pass and the counters hold until the next start.
- Boundary conditions:
  - number == 0: no request, no pops; chk_done fires 2 cycles after start with pass = 1.
  - The maximum number (2^NUM_W − 1) must work without counter overflow.
  - r_done arriving in the same cycle as r_dr_en is accepted.
  - r_done outside WAIT_DONE is ignored.
- Reset mid-operation:
  - Asynchronously returns to IDLE with reset values.
  - r_dr_en and r_fo_en drop immediately.
  - No partial result is posted.

Optional Feature:
- Macro: `SDRAM_READER_TIMEOUT_EN`.
- Defined:
  - A counter runs in WAIT_DONE.
  - If it reaches TIMEOUT without r_done, set timeout = 1 and jump to REPORT with no pops; pass = 0.
- Undefined:
  - No counter; WAIT_DONE waits indefinitely.
  - The timeout port is tied to 0.

Test Plan:
- Clean burst: controller pre-written with 1..256 at address 2; start with base_addr = 2, number = 255, expect_start = 1 → one r_dr_en pulse; 255 r_fo_en cycles after r_done; chk_done with pass = 1, err_cnt = 0, rd_cnt = 255, first_err_idx = 0x1FF.
- Corruption: model returns 0xDEAD at word index 10 and 200 → pass = 0, err_cnt = 2, first_err_idx = 10, first_err_data = 0xDEAD.
- Zero count: start with number = 0 → no r_dr_en, no r_fo_en; chk_done 2 cycles later, pass = 1.
- Wrap: expect_start = 0xFFFFFFFE, number = 4, data FFFFFFFE, FFFFFFFF, 0, 1 → pass = 1.
- Reset mid-POP: rst_n low after 50 pops → r_fo_en low immediately, busy = 0, no chk_done; a fresh start then completes normally.
- Timeout build: r_done withheld, TIMEOUT = 64 → timeout = 1 and pass = 0 about 65 cycles after r_dr_en; zero r_fo_en cycles.

Source files
------------

// File: rtl/sdram_ch_reader.sv
// sdram_ch_reader: read-side self-check for one SDRAM user-port read channel.
// Issues a single chN_r_* read request, waits for r_done, pops the read FIFO
// and compares each word against an incrementing pattern starting at expect_start.
// Optional build macro: SDRAM_READER_TIMEOUT_EN bounds the wait for r_done to
// TIMEOUT cycles; without it the wait is unbounded and timeout_o is always 0.
module sdram_ch_reader #(
    parameter int unsigned ADDR_W  = 21,
    parameter int unsigned NUM_W   = 9,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [NUM_W-1:0]  number_i,
    input  logic [DATA_W-1:0] expect_start_i,
    output logic [ADDR_W-1:0] r_addr_o,
    output logic [NUM_W-1:0]  r_number_o,
    output logic              r_dr_en_o,
    input  logic              r_ack_i,
    input  logic              r_done_i,
    output logic              r_fo_en_o,
    input  logic [DATA_W-1:0] r_data_i,
    output logic              busy_o,
    output logic              chk_done_o,
    output logic              pass_o,
    output logic [NUM_W-1:0]  err_cnt_o,
    output logic [NUM_W-1:0]  rd_cnt_o,
    output logic [NUM_W-1:0]  first_err_idx_o,
    output logic [DATA_W-1:0] first_err_data_o,
    output logic              timeout_o
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StReq    = 3'd1;
    localparam logic [2:0] StWait   = 3'd2;
    localparam logic [2:0] StPop    = 3'd3;
    localparam logic [2:0] StDrain  = 3'd4;
    localparam logic [2:0] StReport = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [NUM_W-1:0]  num_q, num_d;
    logic [DATA_W-1:0] exp_q, exp_d;
    logic [NUM_W-1:0]  pop_cnt_q, pop_cnt_d;
    logic              cmp_vld_q;
    logic [NUM_W-1:0]  err_cnt_q, err_cnt_d;
    logic [NUM_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [NUM_W-1:0]  first_idx_q, first_idx_d;
    logic [DATA_W-1:0] first_data_q, first_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              timeout_q, timeout_d;
    logic              to_hit;

`ifdef SDRAM_READER_TIMEOUT_EN
    localparam int unsigned ToW = $clog2(TIMEOUT + 1);

    logic [ToW-1:0] to_cnt_q, to_cnt_d;

    assign to_hit = (to_cnt_q == ToW'(TIMEOUT - 1));

    // Wait-for-done cycle counter; only runs while waiting for r_done.
    always_comb begin
        to_cnt_d = '0;
        if (state_q == StWait && !r_done_i) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    // Timeout counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    assign to_hit = 1'b0;
`endif

    // Next-state logic: sequencing FSM plus the one-stage compare pipeline.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        num_d        = num_q;
        exp_d        = exp_q;
        pop_cnt_d    = pop_cnt_q;
        err_cnt_d    = err_cnt_q;
        rd_cnt_d     = rd_cnt_q;
        first_idx_d  = first_idx_q;
        first_data_d = first_data_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        pass_d       = pass_q;
        timeout_d    = timeout_q;

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    addr_d       = base_addr_i;
                    num_d        = number_i;
                    exp_d        = expect_start_i;
                    pop_cnt_d    = '0;
                    err_cnt_d    = '0;
                    rd_cnt_d     = '0;
                    first_idx_d  = '1;
                    first_data_d = '0;
                    pass_d       = 1'b0;
                    timeout_d    = 1'b0;
                    busy_d       = 1'b1;
                    state_d      = (number_i == '0) ? StReport : StReq;
                end
            end
            StReq: begin
                // A done arriving alongside the request pulse is taken directly.
                state_d = r_done_i ? StPop : StWait;
            end
            StWait: begin
                if (r_done_i) begin
                    state_d = StPop;
                end else if (to_hit) begin
                    timeout_d = 1'b1;
                    state_d   = StReport;
                end
            end
            StPop: begin
                pop_cnt_d = pop_cnt_q + 1'b1;
                if (pop_cnt_q == num_q - 1'b1) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                state_d = StReport;
            end
            StReport: begin
                pass_d  = (err_cnt_q == '0) && !timeout_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // r_data belongs to the pop issued one cycle earlier.
        if (cmp_vld_q) begin
            if (r_data_i != exp_q) begin
                if (err_cnt_q != '1) begin
                    err_cnt_d = err_cnt_q + 1'b1;
                end
                if (err_cnt_q == '0) begin
                    first_idx_d  = rd_cnt_q;
                    first_data_d = r_data_i;
                end
            end
            rd_cnt_d = rd_cnt_q + 1'b1;
            exp_d    = exp_q + 1'b1;
        end
    end

    // State and result registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            num_q        <= '0;
            exp_q        <= '0;
            pop_cnt_q    <= '0;
            cmp_vld_q    <= 1'b0;
            err_cnt_q    <= '0;
            rd_cnt_q     <= '0;
            first_idx_q  <= '1;
            first_data_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            num_q        <= num_d;
            exp_q        <= exp_d;
            pop_cnt_q    <= pop_cnt_d;
            cmp_vld_q    <= r_fo_en_o;
            err_cnt_q    <= err_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            first_idx_q  <= first_idx_d;
            first_data_q <= first_data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            timeout_q    <= timeout_d;
        end
    end

    // Request/pop strobes decode straight from state so reset drops them at once.
    assign r_dr_en_o        = (state_q == StReq);
    assign r_fo_en_o        = (state_q == StPop);
    assign r_addr_o         = addr_q;
    assign r_number_o       = num_q;
    assign busy_o           = busy_q;
    assign chk_done_o       = done_q;
    assign pass_o           = pass_q;
    assign err_cnt_o        = err_cnt_q;
    assign rd_cnt_o         = rd_cnt_q;
    assign first_err_idx_o  = first_idx_q;
    assign first_err_data_o = first_data_q;
    assign timeout_o        = timeout_q;

    // r_ack only feeds the handshake-order check; TIMEOUT is unused without the timeout build.
    logic unused_cfg;
    assign unused_cfg = r_ack_i ^ (TIMEOUT == 0);

`ifndef SYNTHESIS
    logic ack_seen_q;

    // Remember whether the controller acknowledged the current request.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ack_seen_q <= 1'b0;
        end else if (state_q == StIdle) begin
            ack_seen_q <= 1'b0;
        end else if (r_ack_i) begin
            ack_seen_q <= 1'b1;
        end
    end

    ack_before_done: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (r_done_i && (state_q == StReq || state_q == StWait)) |-> (ack_seen_q || r_ack_i));
`endif

endmodule

// File: tb/tb_sdram_ch_reader.sv
// Scoreboard bench for sdram_ch_reader: a behavioural SDRAM read-channel model
// serves data from a small memory, a reference model predicts each result, and
// a monitor compares every posted result against the queued prediction.
module tb_sdram_ch_reader;

    localparam int AW = 21;
    localparam int NW = 9;
    localparam int DW = 32;
    localparam int TO = 64;
    localparam int MEM_N = 1024;

    typedef struct {
        logic        pass;
        int          errs;
        int          rd;
        int          fidx;
        logic [31:0] fdat;
        logic        tmo;
        int          pops;
        int          reqs;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [NW-1:0] number = '0;
    logic [DW-1:0] expect_start = '0;
    logic [AW-1:0] r_addr;
    logic [NW-1:0] r_number;
    logic          r_dr_en;
    logic          r_ack = 1'b0;
    logic          r_done = 1'b0;
    logic          r_fo_en;
    logic [DW-1:0] r_data = '0;
    logic          busy;
    logic          chk_done;
    logic          pass;
    logic [NW-1:0] err_cnt;
    logic [NW-1:0] rd_cnt;
    logic [NW-1:0] first_err_idx;
    logic [DW-1:0] first_err_data;
    logic          timeout;

    sdram_ch_reader #(
        .ADDR_W (AW),
        .NUM_W  (NW),
        .DATA_W (DW),
        .TIMEOUT(TO)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .start_i         (start),
        .base_addr_i     (base_addr),
        .number_i        (number),
        .expect_start_i  (expect_start),
        .r_addr_o        (r_addr),
        .r_number_o      (r_number),
        .r_dr_en_o       (r_dr_en),
        .r_ack_i         (r_ack),
        .r_done_i        (r_done),
        .r_fo_en_o       (r_fo_en),
        .r_data_i        (r_data),
        .busy_o          (busy),
        .chk_done_o      (chk_done),
        .pass_o          (pass),
        .err_cnt_o       (err_cnt),
        .rd_cnt_o        (rd_cnt),
        .first_err_idx_o (first_err_idx),
        .first_err_data_o(first_err_data),
        .timeout_o       (timeout)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail = 0;
    exp_t        sb[$];
    logic [31:0] mem[0:MEM_N-1];
    int          n_done = 0;
    int          fo_cnt = 0;
    int          dr_cnt = 0;
    int          dly_cfg = 2;
    bit          withhold = 1'b0;
    bit          stray_req = 1'b0;
    logic [AW-1:0] cur_base = '0;
    logic [NW-1:0] cur_num = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: word i of a burst lives at (base+i) mod MEM_N and must equal es+i mod 2^32.
    function automatic exp_t model(input int base, input int num, input logic [31:0] es,
                                   input bit tmo);
        exp_t        e;
        logic [31:0] w;
        e.errs = 0;
        e.fidx = (1 << NW) - 1;
        e.fdat = '0;
        e.tmo  = tmo;
        if (tmo) begin
            e.pass = 1'b0;
            e.rd   = 0;
            e.pops = 0;
            e.reqs = 1;
            return e;
        end
        for (int i = 0; i < num; i++) begin
            w = mem[(base + i) % MEM_N];
            if (w != es + 32'(i)) begin
                if (e.errs == 0) begin
                    e.fidx = i;
                    e.fdat = w;
                end
                e.errs++;
            end
        end
        if (e.errs > (1 << NW) - 1) e.errs = (1 << NW) - 1;
        e.pass = (e.errs == 0);
        e.rd   = num;
        e.pops = num;
        e.reqs = (num != 0) ? 1 : 0;
        return e;
    endfunction

    task automatic fill(input int base, input int num, input logic [31:0] es);
        for (int i = 0; i < num; i++) mem[(base + i) % MEM_N] = es + 32'(i);
    endtask

    // SDRAM read-channel model: ack/done after dly_cfg cycles, data one cycle after each pop.
    bit pend = 1'b0;
    int dcnt = 0;
    bit prev_fo = 1'b0;
    int idx = 0;
    int c_base = 0;
    always @(negedge clk) begin
        r_ack  = 1'b0;
        r_done = 1'b0;
        if (!rst_n) begin
            pend    = 1'b0;
            prev_fo = 1'b0;
            r_data  = $urandom;
        end else begin
            if (prev_fo) begin
                r_data = mem[(c_base + idx) % MEM_N];
                idx++;
            end else begin
                r_data = $urandom;
            end
            prev_fo = r_fo_en;
            if (r_fo_en) fo_cnt++;
            if (r_dr_en) begin
                dr_cnt++;
                chk("req_addr", 64'(r_addr), 64'(cur_base));
                chk("req_number", 64'(r_number), 64'(cur_num));
                c_base = int'(r_addr) % MEM_N;
                idx    = 0;
                dcnt   = dly_cfg;
                pend   = 1'b1;
            end
            if (pend && !withhold) begin
                if (dcnt == 0) begin
                    r_ack  = 1'b1;
                    r_done = 1'b1;
                    pend   = 1'b0;
                end else begin
                    if (dcnt == 1) r_ack = 1'b1;
                    dcnt--;
                end
            end
            if (stray_req) begin
                r_done    = 1'b1;
                stray_req = 1'b0;
            end
        end
    end

    // Monitor: every posted result is checked against the oldest prediction.
    exp_t me;
    always @(negedge clk) begin
        if (rst_n && chk_done) begin
            n_done++;
            if (sb.size() == 0) begin
                chk("unexpected_chk_done", 64'(chk_done), 64'd0);
            end else begin
                me = sb.pop_front();
                chk("pass", 64'(pass), 64'(me.pass));
                chk("err_cnt", 64'(err_cnt), 64'(me.errs));
                chk("rd_cnt", 64'(rd_cnt), 64'(me.rd));
                chk("first_err_idx", 64'(first_err_idx), 64'(me.fidx));
                if (me.errs != 0) chk("first_err_data", 64'(first_err_data), 64'(me.fdat));
                chk("timeout", 64'(timeout), 64'(me.tmo));
                chk("fo_en_cycles", 64'(fo_cnt), 64'(me.pops));
                chk("dr_en_pulses", 64'(dr_cnt), 64'(me.reqs));
                chk("busy_at_done", 64'(busy), 64'd0);
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        sb.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic run(input int base, input int num, input logic [31:0] es, input bit tmo,
                       input int stray_at, input bit ghost);
        int d0;
        sb.push_back(model(base, num, es, tmo));
        cur_base = AW'(base);
        cur_num  = NW'(num);
        fo_cnt   = 0;
        dr_cnt   = 0;
        d0       = n_done;
        @(negedge clk);
        start        = 1'b1;
        base_addr    = AW'(base);
        number       = NW'(num);
        expect_start = es;
        @(negedge clk);
        start        = 1'b0;
        base_addr    = AW'($urandom);
        number       = NW'($urandom);
        expect_start = $urandom;
        chk("busy_after_start", 64'(busy), 64'd1);
        for (int c = 0; c < 3000 && n_done == d0; c++) begin
            @(negedge clk);
            start = ghost && (c == 5);
            if (stray_at >= 0 && fo_cnt == stray_at) stray_req = 1'b1;
        end
        start = 1'b0;
        if (n_done == d0) begin
            chk("chk_done_arrival", 64'(n_done - d0), 64'd1);
            do_reset();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int base, num, d0;
        logic [31:0] es;
        for (int i = 0; i < MEM_N; i++) mem[i] = $urandom;

        repeat (3) @(negedge clk);
        chk("rst_r_addr", 64'(r_addr), 64'd0);
        chk("rst_r_number", 64'(r_number), 64'd0);
        chk("rst_r_dr_en", 64'(r_dr_en), 64'd0);
        chk("rst_r_fo_en", 64'(r_fo_en), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_chk_done", 64'(chk_done), 64'd0);
        chk("rst_pass", 64'(pass), 64'd0);
        chk("rst_err_cnt", 64'(err_cnt), 64'd0);
        chk("rst_rd_cnt", 64'(rd_cnt), 64'd0);
        chk("rst_first_err_idx", 64'(first_err_idx), 64'h1FF);
        chk("rst_first_err_data", 64'(first_err_data), 64'd0);
        chk("rst_timeout", 64'(timeout), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Clean burst of 255 words, with a stray r_done injected mid-POP.
        fill(2, 256, 32'd1);
        run(2, 255, 32'd1, 1'b0, 5, 1'b0);

        // Two corrupted words.
        mem[12]  = 32'hDEAD;
        mem[202] = 32'hDEAD;
        run(2, 255, 32'd1, 1'b0, -1, 1'b0);

        // Zero count: result two cycles after start, no request, no pops.
        sb.push_back(model(0, 0, 32'd0, 1'b0));
        fo_cnt = 0;
        dr_cnt = 0;
        @(negedge clk);
        start  = 1'b1;
        number = '0;
        @(negedge clk);
        start = 1'b0;
        chk("zero_done_early", 64'(chk_done), 64'd0);
        @(negedge clk);
        chk("zero_done_at_2", 64'(chk_done), 64'd1);
        repeat (2) @(negedge clk);

        // Expected pattern wraps through zero.
        fill(100, 4, 32'hFFFF_FFFE);
        run(100, 4, 32'hFFFF_FFFE, 1'b0, -1, 1'b0);

        // Maximum count, with a start pulse ignored while busy.
        dly_cfg = 4;
        fill(300, 511, 32'h1234_5678);
        mem[(300 + 510) % MEM_N] = 32'h0;
        run(300, 511, 32'h1234_5678, 1'b0, -1, 1'b1);

        // r_done in the same cycle as r_dr_en.
        dly_cfg = 0;
        fill(700, 20, 32'hCAFE_0000);
        run(700, 20, 32'hCAFE_0000, 1'b0, -1, 1'b0);

        // Stray r_done while idle does nothing.
        d0 = n_done;
        stray_req = 1'b1;
        repeat (4) @(negedge clk);
        chk("stray_idle_busy", 64'(busy), 64'd0);
        chk("stray_idle_done", 64'(n_done - d0), 64'd0);

        // Randomized bursts with random corruption and controller latency.
        for (int t = 0; t < 12; t++) begin
            base    = $urandom_range(0, 2000000);
            num     = ($urandom_range(0, 7) == 0) ? $urandom_range(100, 511)
                                                  : $urandom_range(1, 60);
            es      = $urandom;
            dly_cfg = $urandom_range(0, 6);
            fill(base, num, es);
            for (int k = 0; k < 3; k++) begin
                if ($urandom_range(0, 2) == 0) begin
                    mem[(base + $urandom_range(0, num - 1)) % MEM_N] = $urandom;
                end
            end
            run(base, num, es, 1'b0, -1, (num >= 20) && ($urandom_range(0, 1) == 1));
        end

        // Reset in the middle of POP: strobes and busy drop at once, no result posted.
        dly_cfg = 2;
        fill(500, 120, 32'd77);
        sb.push_back(model(500, 120, 32'd77, 1'b0));
        cur_base = AW'(500);
        cur_num  = NW'(120);
        fo_cnt   = 0;
        dr_cnt   = 0;
        @(negedge clk);
        start        = 1'b1;
        base_addr    = AW'(500);
        number       = NW'(120);
        expect_start = 32'd77;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 500 && fo_cnt < 50; c++) @(negedge clk);
        chk("pops_before_reset", 64'(fo_cnt >= 50), 64'd1);
        d0    = n_done;
        rst_n = 1'b0;
        #1;
        chk("midrst_fo_en", 64'(r_fo_en), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_chk_done", 64'(chk_done), 64'd0);
        chk("midrst_first_err_idx", 64'(first_err_idx), 64'h1FF);
        sb.delete();
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("midrst_no_result", 64'(n_done - d0), 64'd0);
        fill(40, 30, 32'd9);
        run(40, 30, 32'd9, 1'b0, -1, 1'b0);

`ifdef SDRAM_READER_TIMEOUT_EN
        // r_done withheld: timeout reported, no pops, pass low.
        withhold = 1'b1;
        run(8, 16, 32'd0, 1'b1, -1, 1'b0);
        withhold = 1'b0;
        fill(8, 16, 32'd3);
        run(8, 16, 32'd3, 1'b0, -1, 1'b0);
`endif

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
